// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction word layout, byte-field codes, fetch states
// and the length/illegal decode used by both fetch and decode.
package cpu_pkg;

    // mode[15:14], byte[13:12], opcode[11:8], op1[7:5], op2[4:2], optype[1:0]
    typedef struct packed {
        logic [1:0] mode;
        logic [1:0] byte_f;
        logic [3:0] opcode;
        logic [2:0] op1;
        logic [2:0] op2;
        logic [1:0] optype;
    } ins_word_t;

    localparam int unsigned BYTE_HI = 13;
    localparam int unsigned BYTE_LO = 12;

    localparam logic [1:0] BYTE_ONE = 2'b01;
    localparam logic [1:0] BYTE_TWO = 2'b10;

    typedef enum logic [1:0] {
        StWait0,
        StWait1,
        StPresent
    } fetch_state_e;

    typedef struct packed {
        logic len;      // 0 = one word, 1 = two words
        logic illegal;
    } len_dec_t;

    function automatic len_dec_t decode_len(input logic [1:0] byte_f);
        len_dec_t d;
        d.len     = (byte_f == BYTE_TWO);
        d.illegal = !((byte_f == BYTE_ONE) || (byte_f == BYTE_TWO));
        return d;
    endfunction

endpackage

// File: rtl/ins_fetch.sv
// Instruction fetch: drives the ROM address, waits out the ROM read latency, checks the
// echoed tag, assembles one/two-word instructions and presents them over valid/ready.
module ins_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned      ADDR_W   = 16,
    parameter int unsigned      DATA_W   = 16,
    parameter int unsigned      ROM_LAT  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [ADDR_W-1:0] rom_addr_echo,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [DATA_W-1:0] ins_w0,
    output logic [DATA_W-1:0] ins_w1,
    output logic              ins_len,
    output logic [ADDR_W-1:0] ins_pc,
    output logic              ins_illegal,
    output logic              tag_err
);

    localparam int unsigned CntW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    fetch_state_e      state_q;
    logic [CntW-1:0]   cnt_q;
    logic [ADDR_W-1:0] pc_q;

    logic              capture;
    logic              tag_ok;
    len_dec_t          dec;
    logic [ADDR_W-1:0] next_pc;

    assign capture = (cnt_q == CntW'(ROM_LAT - 1));
    assign tag_ok  = (rom_addr_echo == rom_addr);
    assign dec     = decode_len(rom_data[BYTE_HI:BYTE_LO]);
    assign next_pc = pc_q + ADDR_W'(ins_len) + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StWait0;
            cnt_q       <= '0;
            pc_q        <= RESET_PC;
            rom_addr    <= RESET_PC;
            ins_valid   <= 1'b0;
            ins_w0      <= '0;
            ins_w1      <= '0;
            ins_len     <= 1'b0;
            ins_pc      <= '0;
            ins_illegal <= 1'b0;
            tag_err     <= 1'b0;
        end else begin
            tag_err <= 1'b0;
            // A redirect overrides everything, including a same-cycle capture or accept.
            if (br_valid) begin
                pc_q      <= br_target;
                rom_addr  <= br_target;
                cnt_q     <= '0;
                ins_valid <= 1'b0;
                state_q   <= StWait0;
            end else begin
                unique case (state_q)
                    StWait0: begin
                        if (!capture) begin
                            cnt_q <= cnt_q + CntW'(1);
                        end else if (!tag_ok) begin
                            tag_err <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            ins_w0      <= rom_data;
                            ins_pc      <= pc_q;
                            ins_len     <= dec.len;
                            ins_illegal <= dec.illegal;
                            cnt_q       <= '0;
                            if (dec.len) begin
                                rom_addr <= pc_q + ADDR_W'(1);
                                state_q  <= StWait1;
                            end else begin
                                ins_w1    <= '0;
                                ins_valid <= 1'b1;
                                state_q   <= StPresent;
                            end
                        end
                    end
                    StWait1: begin
                        if (!capture) begin
                            cnt_q <= cnt_q + CntW'(1);
                        end else if (!tag_ok) begin
                            tag_err <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            ins_w1    <= rom_data;
                            ins_valid <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= StPresent;
                        end
                    end
                    StPresent: begin
                        if (ins_valid && ins_ready) begin
                            pc_q      <= next_pc;
                            rom_addr  <= next_pc;
                            cnt_q     <= '0;
                            ins_valid <= 1'b0;
                            state_q   <= StWait0;
                        end
                    end
                    default: begin
                        state_q <= StWait0;
                    end
                endcase
            end
        end
    end

endmodule
